// File: rtl/cr_huf_comp_hw_short_rd_pkg.sv
// Shared types for the short-alphabet tree-result reader.
// Optional histogram build: CR_HUF_COMP_SHORT_RD_HIST_EN.
package cr_huf_compPKG;

    localparam int CR_HUF_COMP_SHORT_RD_LAT = 1;
    localparam int SHORT_RD_SEQID_W = 4;
    localparam int SHORT_RD_COST_W  = 26;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        DONE,
        RESULT
    } e_short_rd_state;

    typedef struct packed {
        logic [SHORT_RD_SEQID_W-1:0] seq_id;
        logic [SHORT_RD_COST_W-1:0]  cost;
        logic                        error;
        logic                        zero;
    } s_short_rd_result;

endpackage

// File: rtl/cr_huf_comp_short_rd_acc.sv
// Pair multiply-accumulate of freq*depth plus optional per-length histogram.
// Latency: one cycle per enabled pair. No backpressure; clr wins over en.
// Histogram counters exist only with CR_HUF_COMP_SHORT_RD_HIST_EN.
module cr_huf_comp_short_rd_acc #(
    parameter int FREQ_WIDTH = 16,
    parameter int CL_WIDTH   = 4,
    parameter int PAIR_AW    = 5
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  clr,
    input  logic                                  en,
    input  logic [2*FREQ_WIDTH-1:0]               freq,
    input  logic [1:0]                            val,
    input  logic [2*CL_WIDTH-1:0]                 dpth,
    output logic [FREQ_WIDTH+CL_WIDTH+PAIR_AW:0]  cost,
    output logic [(2**CL_WIDTH)*(PAIR_AW+2)-1:0]  hist
);
    localparam int PW     = FREQ_WIDTH + CL_WIDTH;
    localparam int HIST_W = PAIR_AW + 2;
    localparam int NUM_CL = 2**CL_WIDTH;

    logic [CL_WIDTH-1:0] d0, d1;
    logic [PW-1:0]       prod0, prod1;
    logic [PW:0]         pair_sum;

    assign d0 = dpth[CL_WIDTH-1:0];
    assign d1 = dpth[2*CL_WIDTH-1:CL_WIDTH];

    // Invalid lanes are masked before the multiply so they add nothing.
    always_comb begin
        prod0 = '0;
        prod1 = '0;
        if (val[0])
            prod0 = {{CL_WIDTH{1'b0}}, freq[FREQ_WIDTH-1:0]} * {{FREQ_WIDTH{1'b0}}, d0};
        if (val[1])
            prod1 = {{CL_WIDTH{1'b0}}, freq[2*FREQ_WIDTH-1:FREQ_WIDTH]} * {{FREQ_WIDTH{1'b0}}, d1};
        pair_sum = {1'b0, prod0} + {1'b0, prod1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cost <= '0;
        else if (clr)
            cost <= '0;
        else if (en)
            cost <= cost + {{PAIR_AW{1'b0}}, pair_sum};
    end

`ifdef CR_HUF_COMP_SHORT_RD_HIST_EN
    logic [HIST_W-1:0] hist_q [NUM_CL];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CL; k++) hist_q[k] <= '0;
        end else if (clr) begin
            for (int k = 0; k < NUM_CL; k++) hist_q[k] <= '0;
        end else if (en) begin
            for (int k = 0; k < NUM_CL; k++)
                hist_q[k] <= hist_q[k]
                           + {{(HIST_W-1){1'b0}}, (val[0] && (d0 == CL_WIDTH'(k)))}
                           + {{(HIST_W-1){1'b0}}, (val[1] && (d1 == CL_WIDTH'(k)))};
        end
    end

    for (genvar g = 0; g < NUM_CL; g++) begin : g_hist
        assign hist[g*HIST_W +: HIST_W] = hist_q[g];
    end
`else
    assign hist = '0;
`endif

endmodule

// File: rtl/cr_huf_comp_hw_short_rd.sv
// Reads the short tree builder's symbol RAM two symbols per cycle, fills the CL table, reports cost.
// Latency: NUM_SYM/2+3 cycles eob->res_valid (2 for error/zero blocks); res_* held until res_ready.
// Histogram output populated only with CR_HUF_COMP_SHORT_RD_HIST_EN.
module cr_huf_comp_hw_short_rd
    import cr_huf_compPKG::*;
#(
    parameter int NUM_SYM     = 64,
    parameter int FREQ_WIDTH  = 16,
    parameter int CL_WIDTH    = 4,
    parameter int SEQID_WIDTH = 4,
    localparam int PAIR_AW    = $clog2(NUM_SYM/2)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     ht_eob,
    input  logic [SEQID_WIDTH-1:0]                   ht_seq_id,
    input  logic                                     ht_zero_symbols,
    input  logic                                     ht_build_error,
    input  logic [2*FREQ_WIDTH-1:0]                  ht_sym_freq,
    input  logic [1:0]                               ht_sym_freq_val,
    input  logic [2*CL_WIDTH-1:0]                    ht_sym_dpth,
    output logic                                     hw_sym_freq_rd,
    output logic [PAIR_AW-1:0]                       hw_sym_freq_addr,
    output logic [SEQID_WIDTH-1:0]                   hw_seq_id,
    output logic                                     hw_rd_done,
    output logic                                     hw_not_ready,
    output logic                                     cl_wr,
    output logic [PAIR_AW-1:0]                       cl_wr_addr,
    output logic [2*CL_WIDTH-1:0]                    cl_wr_data,
    output logic                                     res_valid,
    input  logic                                     res_ready,
    output logic [SEQID_WIDTH-1:0]                   res_seq_id,
    output logic [FREQ_WIDTH+CL_WIDTH+PAIR_AW:0]     res_cost,
    output logic                                     res_error,
    output logic                                     res_zero,
    output logic [(2**CL_WIDTH)*(PAIR_AW+2)-1:0]     res_cl_hist
);
    localparam int COST_W = FREQ_WIDTH + CL_WIDTH + PAIR_AW + 1;
    localparam logic [PAIR_AW-1:0] LAST_ADDR = PAIR_AW'(NUM_SYM/2 - 1);

    e_short_rd_state         state_q, state_d;
    logic [PAIR_AW-1:0]      addr_q, rd_addr_q;
    logic                    rd_q;
    logic [SEQID_WIDTH-1:0]  seq_q;
    logic                    err_q, zero_q;
    s_short_rd_result        res_q;
    logic                    accept;
    logic [COST_W-1:0]       acc_cost;

    assign accept = (state_q == IDLE) && ht_eob;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (ht_eob) state_d = (ht_build_error || ht_zero_symbols) ? DONE : READ;
            READ:   if (addr_q == LAST_ADDR) state_d = DRAIN;
            DRAIN:  state_d = DONE;
            DONE:   state_d = RESULT;
            RESULT: if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Builder RAM returns data one cycle after the strobe; rd_q/rd_addr_q track that return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            rd_addr_q <= '0;
            rd_q      <= 1'b0;
            seq_q     <= '0;
            err_q     <= 1'b0;
            zero_q    <= 1'b0;
            res_q     <= '0;
        end else begin
            rd_q      <= (state_q == READ);
            rd_addr_q <= addr_q;
            if (accept) begin
                addr_q <= '0;
                seq_q  <= ht_seq_id;
                err_q  <= ht_build_error;
                zero_q <= ht_zero_symbols;
            end else if (state_q == READ) begin
                addr_q <= addr_q + 1'b1;
            end
            if (state_q == DONE) begin
                res_q.seq_id <= SHORT_RD_SEQID_W'(seq_q);
                res_q.cost   <= SHORT_RD_COST_W'(acc_cost);
                res_q.error  <= err_q;
                res_q.zero   <= zero_q;
            end
        end
    end

    cr_huf_comp_short_rd_acc #(
        .FREQ_WIDTH (FREQ_WIDTH),
        .CL_WIDTH   (CL_WIDTH),
        .PAIR_AW    (PAIR_AW)
    ) u_acc (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .en   (rd_q),
        .freq (ht_sym_freq),
        .val  (ht_sym_freq_val),
        .dpth (ht_sym_dpth),
        .cost (acc_cost),
        .hist (res_cl_hist)
    );

    assign hw_sym_freq_rd   = (state_q == READ);
    assign hw_sym_freq_addr = addr_q;
    assign hw_seq_id        = seq_q;
    assign hw_rd_done       = (state_q == DONE);
    assign hw_not_ready     = (state_q != IDLE);
    assign cl_wr            = rd_q;
    assign cl_wr_addr       = rd_addr_q;
    assign cl_wr_data       = rd_q ? ht_sym_dpth : '0;
    assign res_valid        = (state_q == RESULT);
    assign res_seq_id       = SEQID_WIDTH'(res_q.seq_id);
    assign res_cost         = COST_W'(res_q.cost);
    assign res_error        = res_q.error;
    assign res_zero         = res_q.zero;

endmodule

// File: tb/tb_cr_huf_comp_hw_short_rd.sv
// Directed bench for cr_huf_comp_hw_short_rd with a 1-cycle builder RAM responder.
// Histogram expectations follow CR_HUF_COMP_SHORT_RD_HIST_EN.
module tb_cr_huf_comp_hw_short_rd;

    localparam int HIST_W = 7;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ht_eob = 1'b0;
    logic [3:0]   ht_seq_id = '0;
    logic         ht_zero_symbols = 1'b0;
    logic         ht_build_error = 1'b0;
    logic [31:0]  ht_sym_freq = '0;
    logic [1:0]   ht_sym_freq_val = '0;
    logic [7:0]   ht_sym_dpth = '0;
    logic         hw_sym_freq_rd;
    logic [4:0]   hw_sym_freq_addr;
    logic [3:0]   hw_seq_id;
    logic         hw_rd_done;
    logic         hw_not_ready;
    logic         cl_wr;
    logic [4:0]   cl_wr_addr;
    logic [7:0]   cl_wr_data;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [3:0]   res_seq_id;
    logic [25:0]  res_cost;
    logic         res_error;
    logic         res_zero;
    logic [111:0] res_cl_hist;

    cr_huf_comp_hw_short_rd dut (
        .clk(clk), .rst(rst), .ht_eob(ht_eob), .ht_seq_id(ht_seq_id),
        .ht_zero_symbols(ht_zero_symbols), .ht_build_error(ht_build_error),
        .ht_sym_freq(ht_sym_freq), .ht_sym_freq_val(ht_sym_freq_val), .ht_sym_dpth(ht_sym_dpth),
        .hw_sym_freq_rd(hw_sym_freq_rd), .hw_sym_freq_addr(hw_sym_freq_addr), .hw_seq_id(hw_seq_id),
        .hw_rd_done(hw_rd_done), .hw_not_ready(hw_not_ready), .cl_wr(cl_wr), .cl_wr_addr(cl_wr_addr),
        .cl_wr_data(cl_wr_data), .res_valid(res_valid), .res_ready(res_ready), .res_seq_id(res_seq_id),
        .res_cost(res_cost), .res_error(res_error), .res_zero(res_zero), .res_cl_hist(res_cl_hist)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [15:0] f0 [32];
    logic [15:0] f1 [32];
    logic [3:0]  d0 [32];
    logic [3:0]  d1 [32];
    logic [1:0]  vl [32];

    int cyc = 0;
    int rd_cnt, first_rd, last_rd, wr_cnt, first_wr, done_cnt, done_cyc, first_val;
    logic [7:0] cl0_data;
    logic [4:0] prev_addr = '0;

    // Builder model and monitor: data for the previous cycle's address, outputs sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            ht_sym_freq     = {f1[prev_addr], f0[prev_addr]};
            ht_sym_dpth     = {d1[prev_addr], d0[prev_addr]};
            ht_sym_freq_val = vl[prev_addr];
            #1;
            if (hw_sym_freq_rd) begin
                if (rd_cnt == 0) first_rd = cyc;
                last_rd = cyc;
                rd_cnt++;
            end
            if (cl_wr) begin
                if (wr_cnt == 0) first_wr = cyc;
                wr_cnt++;
                if (cl_wr_addr == 5'd0) cl0_data = cl_wr_data;
            end
            if (hw_rd_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (res_valid && first_val < 0) first_val = cyc;
            prev_addr = hw_sym_freq_addr;
        end
    end

    task automatic clear_mon();
        rd_cnt = 0; first_rd = -1; last_rd = -1; wr_cnt = 0; first_wr = -1;
        done_cnt = 0; done_cyc = -1; first_val = -1; cl0_data = 8'hxx;
    endtask

    task automatic set_mem(input logic [15:0] f, input logic [3:0] d, input logic [1:0] v);
        for (int i = 0; i < 32; i++) begin
            f0[i] = f; f1[i] = f; d0[i] = d; d1[i] = d; vl[i] = v;
        end
    endtask

    task automatic send_eob(input logic [3:0] seq, input logic err, input logic zero, output int t);
        @(negedge clk); #2;
        ht_eob = 1'b1; ht_seq_id = seq; ht_build_error = err; ht_zero_symbols = zero;
        t = cyc;
        @(negedge clk); #2;
        ht_eob = 1'b0; ht_build_error = 1'b0; ht_zero_symbols = 1'b0;
    endtask

    task automatic wait_result(input int bound);
        for (int i = 0; i < bound && !res_valid; i++) begin
            @(negedge clk); #2;
        end
        checks++;
        if (res_valid !== 1'b1) begin
            failures++;
            $display("FAIL wait_result: res_valid=%b required 1 within %0d cycles", res_valid, bound);
        end
    endtask

    task automatic accept_result();
        res_ready = 1'b1;
        @(negedge clk); #2;
        res_ready = 1'b0;
        checks++;
        if (hw_not_ready !== 1'b0 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL accept: not_ready=%b valid=%b required 0 0", hw_not_ready, res_valid);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({hw_sym_freq_rd, hw_rd_done, hw_not_ready, cl_wr, res_valid, res_error, res_zero} !== 7'b0) begin
            failures++;
            $display("FAIL reset_flags: rd/done/nrdy/clwr/val/err/zero=%b required 0", 
                     {hw_sym_freq_rd, hw_rd_done, hw_not_ready, cl_wr, res_valid, res_error, res_zero});
        end
        checks++;
        if (res_cost !== 26'd0 || res_cl_hist !== 112'd0 || hw_seq_id !== 4'd0 || cl_wr_data !== 8'd0) begin
            failures++;
            $display("FAIL reset_data: cost=%0d hist=%h seq=%0d cldata=%h required all 0",
                     res_cost, res_cl_hist, hw_seq_id, cl_wr_data);
        end
    endtask

    task automatic run_uniform(input logic [3:0] seq, input string tag);
        int t;
        set_mem(16'd1, 4'd6, 2'b11);
        clear_mon();
        send_eob(seq, 1'b0, 1'b0, t);
        wait_result(60);
        checks++;
        if (rd_cnt != 32 || first_rd != t + 1 || last_rd != t + 32) begin
            failures++;
            $display("FAIL %s reads: cnt=%0d first=%0d last=%0d required 32 %0d %0d",
                     tag, rd_cnt, first_rd, last_rd, t + 1, t + 32);
        end
        checks++;
        if (wr_cnt != 32 || first_wr != t + 2) begin
            failures++;
            $display("FAIL %s cl_wr: cnt=%0d first=%0d required 32 %0d", tag, wr_cnt, first_wr, t + 2);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != t + 34 || first_val != t + 35) begin
            failures++;
            $display("FAIL %s timing: done_cnt=%0d done=%0d valid=%0d required 1 %0d %0d",
                     tag, done_cnt, done_cyc, first_val, t + 34, t + 35);
        end
        checks++;
        if (res_cost !== 26'd384 || res_seq_id !== seq || res_error !== 1'b0 || res_zero !== 1'b0) begin
            failures++;
            $display("FAIL %s result: cost=%0d seq=%0d err=%b zero=%b required 384 %0d 0 0",
                     tag, res_cost, res_seq_id, res_error, res_zero, seq);
        end
`ifdef CR_HUF_COMP_SHORT_RD_HIST_EN
        checks++;
        if (res_cl_hist[6*HIST_W +: HIST_W] !== 7'd64 || res_cl_hist[5*HIST_W +: HIST_W] !== 7'd0) begin
            failures++;
            $display("FAIL %s hist: hist6=%0d hist5=%0d required 64 0", tag,
                     res_cl_hist[6*HIST_W +: HIST_W], res_cl_hist[5*HIST_W +: HIST_W]);
        end
`else
        checks++;
        if (res_cl_hist !== 112'd0) begin
            failures++;
            $display("FAIL %s hist_off: hist=%h required 0", tag, res_cl_hist);
        end
`endif
        accept_result();
    endtask

    task automatic test_uniform();
        run_uniform(4'd3, "uniform");
    endtask

    task automatic test_pair0();
        int t;
        set_mem(16'd5, 4'd3, 2'b00);
        f0[0] = 16'd100; f1[0] = 16'd3; d0[0] = 4'd1; d1[0] = 4'd9; vl[0] = 2'b01;
        clear_mon();
        send_eob(4'd7, 1'b0, 1'b0, t);
        wait_result(60);
        checks++;
        if (res_cost !== 26'd100 || res_seq_id !== 4'd7) begin
            failures++;
            $display("FAIL pair0 cost: cost=%0d seq=%0d required 100 7", res_cost, res_seq_id);
        end
        checks++;
        if (cl0_data !== 8'h91 || wr_cnt != 32) begin
            failures++;
            $display("FAIL pair0 cl_wr: data=%h cnt=%0d required 91 32", cl0_data, wr_cnt);
        end
`ifdef CR_HUF_COMP_SHORT_RD_HIST_EN
        checks++;
        if (res_cl_hist[1*HIST_W +: HIST_W] !== 7'd1 || res_cl_hist[9*HIST_W +: HIST_W] !== 7'd0
            || res_cl_hist[3*HIST_W +: HIST_W] !== 7'd0) begin
            failures++;
            $display("FAIL pair0 hist: h1=%0d h9=%0d h3=%0d required 1 0 0",
                     res_cl_hist[1*HIST_W +: HIST_W], res_cl_hist[9*HIST_W +: HIST_W],
                     res_cl_hist[3*HIST_W +: HIST_W]);
        end
`endif
        accept_result();
    endtask

    task automatic test_error();
        int t;
        set_mem(16'd1, 4'd6, 2'b11);
        clear_mon();
        send_eob(4'd2, 1'b1, 1'b0, t);
        wait_result(10);
        checks++;
        if (rd_cnt != 0 || done_cnt != 1 || done_cyc != t + 1 || first_val != t + 2) begin
            failures++;
            $display("FAIL error timing: reads=%0d done_cnt=%0d done=%0d valid=%0d required 0 1 %0d %0d",
                     rd_cnt, done_cnt, done_cyc, first_val, t + 1, t + 2);
        end
        checks++;
        if (res_error !== 1'b1 || res_zero !== 1'b0 || res_cost !== 26'd0 || res_cl_hist !== 112'd0) begin
            failures++;
            $display("FAIL error result: err=%b zero=%b cost=%0d hist=%h required 1 0 0 0",
                     res_error, res_zero, res_cost, res_cl_hist);
        end
        accept_result();
        clear_mon();
        send_eob(4'd4, 1'b0, 1'b1, t);
        wait_result(10);
        checks++;
        if (rd_cnt != 0 || res_zero !== 1'b1 || res_error !== 1'b0 || res_cost !== 26'd0) begin
            failures++;
            $display("FAIL zero result: reads=%0d zero=%b err=%b cost=%0d required 0 1 0 0",
                     rd_cnt, res_zero, res_error, res_cost);
        end
        accept_result();
    endtask

    task automatic test_backpressure();
        int t;
        int bad = 0;
        set_mem(16'd2, 4'd5, 2'b11);
        clear_mon();
        send_eob(4'd5, 1'b0, 1'b0, t);
        wait_result(60);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin ht_eob = 1'b1; ht_seq_id = 4'd9; end
            if (i == 5) ht_eob = 1'b0;
            @(negedge clk); #2;
            if (res_valid !== 1'b1 || hw_not_ready !== 1'b1 || res_cost !== 26'd640
                || res_seq_id !== 4'd5 || hw_seq_id !== 4'd5) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL backpressure stable: %0d unstable cycles, cost=%0d seq=%0d required 640 5",
                     bad, res_cost, res_seq_id);
        end
        accept_result();
        clear_mon();
        repeat (5) @(negedge clk);
        #2;
        checks++;
        if (rd_cnt != 0 || hw_not_ready !== 1'b0 || done_cnt != 0) begin
            failures++;
            $display("FAIL ignored_eob: reads=%0d not_ready=%b done=%0d required 0 0 0",
                     rd_cnt, hw_not_ready, done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        set_mem(16'd1, 4'd6, 2'b11);
        clear_mon();
        send_eob(4'd8, 1'b0, 1'b0, t);
        for (int i = 0; i < 40 && rd_cnt < 10; i++) begin
            @(negedge clk); #2;
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({hw_sym_freq_rd, hw_rd_done, hw_not_ready, cl_wr, res_valid} !== 5'b0
            || hw_seq_id !== 4'd0 || res_cost !== 26'd0 || cl_wr_data !== 8'd0 || res_cl_hist !== 112'd0) begin
            failures++;
            $display("FAIL reset_mid: rd/done/nrdy/clwr/val=%b seq=%0d cost=%0d required all 0",
                     {hw_sym_freq_rd, hw_rd_done, hw_not_ready, cl_wr, res_valid}, hw_seq_id, res_cost);
        end
        @(negedge clk); #2;
        rst = 1'b0;
        clear_mon();
        repeat (40) @(negedge clk);
        #2;
        checks++;
        if (done_cnt != 0 || first_val != -1 || rd_cnt != 0) begin
            failures++;
            $display("FAIL reset_abandon: done=%0d valid_cyc=%0d reads=%0d required 0 -1 0",
                     done_cnt, first_val, rd_cnt);
        end
        run_uniform(4'd11, "after_reset");
    endtask

    initial begin
        clear_mon();
        set_mem(16'd0, 4'd0, 2'b00);
        repeat (3) @(negedge clk);
        #2;
        test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_uniform();
        test_pair0();
        test_error();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
